// File: rtl/rv32i_wb_port_arbiter.sv
// Register-file write-port arbiter between pipeline write-back and the mul/div unit.
// Optional perf counters are enabled by defining WB_ARB_PERF_EN.
module rv32i_wb_port_arbiter #(
  parameter int WIDTH    = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wb_valid,
  input  logic [4:0]       i_wb_rd,
  input  logic [WIDTH-1:0] i_wb_data,
  output logic             o_pipe_stall,
  input  logic             i_md_valid,
  input  logic [4:0]       i_md_rd,
  input  logic [WIDTH-1:0] i_md_data,
  output logic             o_md_ready,
  output logic             o_rf_we,
  output logic [4:0]       o_rf_rd,
  output logic [WIDTH-1:0] o_rf_data,
  output logic             o_rf_src_md
`ifdef WB_ARB_PERF_EN
  ,
  output logic [31:0]      o_perf_stall_cnt,
  output logic [31:0]      o_perf_md_wr_cnt
`endif
);

  localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_PEND = 1'b1} state_t;

  state_t           state_r, state_nxt_s;
  logic [4:0]       pend_rd_r, pend_rd_nxt_s;
  logic [WIDTH-1:0] pend_data_r, pend_data_nxt_s;
  logic [CW-1:0]    wait_cnt_r, wait_nxt_s;
  logic             wb_req_s, md_grant_s, pipe_grant_s, md_ready_s, md_accept_s;

  // x0 writes never contend for the port
  assign wb_req_s = i_wb_valid && (i_wb_rd != 5'd0);

  // State, holding register and wait counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= ST_IDLE;
      pend_rd_r   <= 5'd0;
      pend_data_r <= '0;
      wait_cnt_r  <= '0;
    end else begin
      state_r     <= state_nxt_s;
      pend_rd_r   <= pend_rd_nxt_s;
      pend_data_r <= pend_data_nxt_s;
      wait_cnt_r  <= wait_nxt_s;
    end
  end

  // Arbitration, next state and port outputs
  always_comb begin
    state_nxt_s     = state_r;
    pend_rd_nxt_s   = pend_rd_r;
    pend_data_nxt_s = pend_data_r;
    wait_nxt_s      = wait_cnt_r;
    md_grant_s      = 1'b0;
    pipe_grant_s    = 1'b0;
    o_pipe_stall    = 1'b0;
    o_md_ready      = 1'b1;
    o_rf_we         = 1'b0;
    o_rf_rd         = 5'd0;
    o_rf_data       = '0;
    o_rf_src_md     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        md_grant_s   = 1'b0;
        pipe_grant_s = wb_req_s;
      end
      ST_PEND: begin
        // Same-rd rule keeps the older mul/div write ahead of the pipeline write
        md_grant_s   = !wb_req_s || (i_wb_rd == pend_rd_r) || (wait_cnt_r == WAIT_LAST);
        pipe_grant_s = wb_req_s && !md_grant_s;
      end
      default: begin
        md_grant_s   = 1'b0;
        pipe_grant_s = 1'b0;
      end
    endcase

    md_ready_s  = (state_r == ST_IDLE) || md_grant_s;
    md_accept_s = i_md_valid && md_ready_s;

    if (md_accept_s && (i_md_rd != 5'd0)) begin
      state_nxt_s     = ST_PEND;
      pend_rd_nxt_s   = i_md_rd;
      pend_data_nxt_s = i_md_data;
      wait_nxt_s      = '0;
    end else if (md_grant_s) begin
      state_nxt_s = ST_IDLE;
    end else if ((state_r == ST_PEND) && (wait_cnt_r != WAIT_LAST)) begin
      wait_nxt_s = wait_cnt_r + CW'(1);
    end else begin
      state_nxt_s = state_r;
    end

    if (i_rst) begin
      o_md_ready = 1'b1;
    end else if (md_grant_s) begin
      o_md_ready   = 1'b1;
      o_rf_we      = 1'b1;
      o_rf_rd      = pend_rd_r;
      o_rf_data    = pend_data_r;
      o_rf_src_md  = 1'b1;
      o_pipe_stall = wb_req_s;
    end else if (pipe_grant_s) begin
      o_md_ready = md_ready_s;
      o_rf_we    = 1'b1;
      o_rf_rd    = i_wb_rd;
      o_rf_data  = i_wb_data;
    end else begin
      o_md_ready = md_ready_s;
    end
  end

`ifdef WB_ARB_PERF_EN
  // Stall-cycle and mul/div-write event counters, free-running and wrapping
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_perf_stall_cnt <= 32'd0;
      o_perf_md_wr_cnt <= 32'd0;
    end else begin
      o_perf_stall_cnt <= o_perf_stall_cnt + {31'd0, o_pipe_stall};
      o_perf_md_wr_cnt <= o_perf_md_wr_cnt + {31'd0, o_rf_we && o_rf_src_md};
    end
  end
`endif

endmodule
